// File: rtl/fifo_pkg.sv
// Shared FIFO controller definitions: FWFT state encoding and pointer width derivation.
package fifo_pkg;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_VALID = 1'b1
  } fwft_state_e;

  // One extra pointer bit distinguishes full from empty when the low bits match.
  localparam int unsigned PTR_EXTRA_BITS = 1;

  function automatic int unsigned ptr_width(input int unsigned addr_width);
    return addr_width + PTR_EXTRA_BITS;
  endfunction

endpackage

// File: rtl/fifo_ptr.sv
// Wrapping FIFO pointer: advances by STEP when enabled, wraps by natural overflow.
module fifo_ptr #(
  parameter int unsigned WIDTH = 7,
  parameter int unsigned STEP  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  output logic [WIDTH-1:0] ptr,
  output logic [WIDTH-1:0] ptr_nxt
);

  localparam logic [WIDTH-1:0] STEP_W = WIDTH'(STEP);

  logic [WIDTH-1:0] ptr_q;
  logic [WIDTH-1:0] ptr_d;

  always_comb begin
    ptr_d = ptr_q;
    if (en) ptr_d = ptr_q + STEP_W;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

  assign ptr     = ptr_q;
  assign ptr_nxt = ptr_d;

endmodule

// File: rtl/sync_fifo_ctrl.sv
// Single-clock mixed-width FIFO controller: pointers, RAM control and status flags.
// Define SYNC_FIFO_FWFT_EN for first-word-fall-through reads; default is standard 1-cycle reads.
module sync_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter int unsigned RAM_DEPTH      = 64,
  parameter int unsigned RAM_ADDR_WIDTH = 6,
  parameter int unsigned WR_IND         = 4,
  parameter int unsigned RD_IND         = 8,
  parameter int unsigned AF_LEVEL       = 48,
  parameter int unsigned AE_LEVEL       = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic                      ram_wr_en,
  output logic [RAM_ADDR_WIDTH-1:0] ram_wr_addr,
  output logic [RAM_ADDR_WIDTH-1:0] ram_rd_addr,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic                      almost_empty,
  output logic                      rd_valid,
  output logic [RAM_ADDR_WIDTH:0]   fill_cnt,
  output logic                      wr_err,
  output logic                      rd_err
);

  localparam int unsigned PW = ptr_width(RAM_ADDR_WIDTH);

  localparam logic [PW-1:0] RD_STEP  = PW'(RD_IND);
  localparam logic [PW-1:0] FULL_LIM = PW'(RAM_DEPTH - WR_IND);
  localparam logic [PW-1:0] AF_LIM   = PW'(AF_LEVEL);
  localparam logic [PW-1:0] AE_LIM   = PW'(AE_LEVEL);

  logic          wr_acc, rd_acc, empty_w;
  logic [PW-1:0] wr_ptr, wr_ptr_nxt, rd_ptr, rd_ptr_nxt;
  logic [PW-1:0] fill, fill_d;
  logic          full_q, full_d, af_q, af_d, ae_q, ae_d;
  logic          wr_err_q, wr_err_d, rd_err_q, rd_err_d;

  assign wr_acc = wr_en & ~full_q;

  fifo_ptr #(.WIDTH(PW), .STEP(WR_IND)) u_wr_ptr (
    .clk(clk), .rst(rst), .en(wr_acc), .ptr(wr_ptr), .ptr_nxt(wr_ptr_nxt)
  );

  fifo_ptr #(.WIDTH(PW), .STEP(RD_IND)) u_rd_ptr (
    .clk(clk), .rst(rst), .en(rd_acc), .ptr(rd_ptr), .ptr_nxt(rd_ptr_nxt)
  );

  // Fill is the pointer difference; the next-pointer difference equals the incremental update.
  assign fill = wr_ptr - rd_ptr;

  always_comb begin
    fill_d   = wr_ptr_nxt - rd_ptr_nxt;
    full_d   = fill_d > FULL_LIM;
    af_d     = fill_d >= AF_LIM;
    ae_d     = fill_d <= AE_LIM;
    wr_err_d = wr_en & full_q;
    rd_err_d = rd_en & empty_w;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q   <= 1'b0;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      wr_err_q <= 1'b0;
      rd_err_q <= 1'b0;
    end else begin
      full_q   <= full_d;
      af_q     <= af_d;
      ae_q     <= ae_d;
      wr_err_q <= wr_err_d;
      rd_err_q <= rd_err_d;
    end
  end

`ifdef SYNC_FIFO_FWFT_EN
  fwft_state_e state_q, state_d;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_EMPTY: if (fill >= RD_STEP) state_d = S_VALID;
      S_VALID: if (rd_en) state_d = ((fill - RD_STEP) >= RD_STEP) ? S_VALID : S_EMPTY;
      default: state_d = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_EMPTY;
    else     state_q <= state_d;
  end

  assign rd_valid    = (state_q == S_VALID);
  assign empty_w     = ~rd_valid;
  assign rd_acc      = rd_en & rd_valid;
  // Next read pointer is rd_ptr when holding and rd_ptr + RD_IND on a pop: the look-ahead address.
  assign ram_rd_addr = rd_ptr_nxt[RAM_ADDR_WIDTH-1:0];
`else
  logic empty_q, empty_d, rd_valid_q;

  assign empty_d = fill_d < RD_STEP;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      empty_q    <= 1'b1;
      rd_valid_q <= 1'b0;
    end else begin
      empty_q    <= empty_d;
      rd_valid_q <= rd_acc;
    end
  end

  assign empty_w     = empty_q;
  assign rd_acc      = rd_en & ~empty_q;
  assign rd_valid    = rd_valid_q;
  assign ram_rd_addr = rd_ptr[RAM_ADDR_WIDTH-1:0];
`endif

  assign ram_wr_en    = wr_acc;
  assign ram_wr_addr  = wr_ptr[RAM_ADDR_WIDTH-1:0];
  assign full         = full_q;
  assign empty        = empty_w;
  assign almost_full  = af_q;
  assign almost_empty = ae_q;
  assign fill_cnt     = fill;
  assign wr_err       = wr_err_q;
  assign rd_err       = rd_err_q;

endmodule

// File: tb/tb_sync_fifo_ctrl.sv
// Self-checking bench for sync_fifo_ctrl: behavioural RAM, reference model and read-data scoreboard.
module tb_sync_fifo_ctrl;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int WR    = 4;
  localparam int RD    = 8;
  localparam int AF    = 48;
  localparam int AE    = 16;

  logic          clk = 1'b0;
  logic          rst, wr_en, rd_en;
  logic          ram_wr_en, full, empty, almost_full, almost_empty, rd_valid, wr_err, rd_err;
  logic [AW-1:0] ram_wr_addr, ram_rd_addr;
  logic [AW:0]   fill_cnt;

  always #5 clk = ~clk;

  sync_fifo_ctrl #(
    .RAM_DEPTH(DEPTH), .RAM_ADDR_WIDTH(AW), .WR_IND(WR), .RD_IND(RD),
    .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .rd_en(rd_en),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .ram_rd_addr(ram_rd_addr),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .rd_valid(rd_valid), .fill_cnt(fill_cnt), .wr_err(wr_err), .rd_err(rd_err)
  );

  // Behavioural mixed-width RAM: 8-bit units, 4-unit write word, 8-unit registered read word.
  logic [7:0]  mem [DEPTH];
  logic [31:0] wr_data;
  logic [63:0] rd_data;

  always @(posedge clk) begin
    if (ram_wr_en)
      for (int i = 0; i < WR; i++) mem[(int'(ram_wr_addr) + i) % DEPTH] <= wr_data[8*i +: 8];
    for (int i = 0; i < RD; i++) rd_data[8*i +: 8] <= mem[(int'(ram_rd_addr) + i) % DEPTH];
  end

  int errors = 0;
  int checks = 0;

  int m_fill, m_wp, m_rp, seq;
  bit m_valid, m_rdv;
  logic [7:0]  unit_q [$];
  logic [63:0] rd_q [$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic bit m_empty();
`ifdef SYNC_FIFO_FWFT_EN
    return !m_valid;
`else
    return m_fill < RD;
`endif
  endfunction

  task automatic check_status(input bit werr, input bit rerr);
    check("full",         64'(full),         64'(m_fill > DEPTH - WR));
    check("empty",        64'(empty),        64'(m_empty()));
    check("almost_full",  64'(almost_full),  64'(m_fill >= AF));
    check("almost_empty", 64'(almost_empty), 64'(m_fill <= AE));
    check("fill_cnt",     64'(fill_cnt),     64'(m_fill));
    check("wr_err",       64'(wr_err),       64'(werr));
    check("rd_err",       64'(rd_err),       64'(rerr));
`ifdef SYNC_FIFO_FWFT_EN
    check("rd_valid",     64'(rd_valid),     64'(m_valid));
`else
    check("rd_valid",     64'(rd_valid),     64'(m_rdv));
`endif
  endtask

  task automatic do_reset();
    wr_en = 1'b0;
    rd_en = 1'b0;
    rst   = 1'b1;
    m_fill = 0; m_wp = 0; m_rp = 0;
    m_valid = 1'b0; m_rdv = 1'b0;
    unit_q.delete();
    rd_q.delete();
    #2;
    check_status(1'b0, 1'b0);
    check("rst_wr_addr", 64'(ram_wr_addr), 64'd0);
    check("rst_rd_addr", 64'(ram_rd_addr), 64'd0);
    check("rst_wr_en",   64'(ram_wr_en),   64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic step(input bit w, input bit r);
    bit wa, ra, werr, rerr;
    int old_fill, exp_rd_addr;
    logic [63:0] word;
    word = '0;
    wr_en = w;
    rd_en = r;
    old_fill = m_fill;
    wa = w && !(m_fill > DEPTH - WR);
`ifdef SYNC_FIFO_FWFT_EN
    ra = r && m_valid;
    exp_rd_addr = (ra ? m_rp + RD : m_rp) % DEPTH;
`else
    ra = r && (m_fill >= RD);
    exp_rd_addr = m_rp % DEPTH;
`endif
    werr = w && !wa;
    rerr = r && m_empty();
    for (int i = 0; i < WR; i++) wr_data[8*i +: 8] = 8'(seq + i);
    if (wa) begin
      for (int i = 0; i < WR; i++) unit_q.push_back(8'(seq + i));
      seq += WR;
    end
    if (ra)
      for (int i = 0; i < RD; i++)
        if (unit_q.size() > 0) word[8*i +: 8] = unit_q.pop_front();
    #1;
    check("ram_wr_en",   64'(ram_wr_en),   64'(wa));
    check("ram_wr_addr", 64'(ram_wr_addr), 64'(m_wp % DEPTH));
    check("ram_rd_addr", 64'(ram_rd_addr), 64'(exp_rd_addr));
`ifdef SYNC_FIFO_FWFT_EN
    if (ra) check("fwft_data", rd_data, word);
    if (!m_valid)   m_valid = old_fill >= RD;
    else if (r)     m_valid = (old_fill - RD) >= RD;
`else
    if (ra) rd_q.push_back(word);
    m_rdv = ra;
`endif
    m_fill = m_fill + (wa ? WR : 0) - (ra ? RD : 0);
    m_wp   = (m_wp + (wa ? WR : 0)) % (2 * DEPTH);
    m_rp   = (m_rp + (ra ? RD : 0)) % (2 * DEPTH);
    @(posedge clk);
    #1;
    check_status(werr, rerr);
`ifndef SYNC_FIFO_FWFT_EN
    if (rd_valid === 1'b1) begin
      if (rd_q.size() == 0) check("rd_unexpected", 64'd1, 64'd0);
      else                  check("rd_data", rd_data, rd_q.pop_front());
    end
`endif
  endtask

  initial begin
    seq = 0;
    do_reset();

    // read on empty, then fill to full and overrun
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    repeat (17) step(1'b1, 1'b0);

    // asynchronous reset while full
    do_reset();

    // two writes, one read
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // half-full, then simultaneous write+read drifting down through almost_empty
    repeat (8) step(1'b1, 1'b0);
    repeat (8) step(1'b1, 1'b1);
    repeat (6) step(1'b0, 1'b1);

    // fill/drain rounds crossing the address wrap
    do_reset();
    repeat (2) begin
      repeat (12) step(1'b1, 1'b0);
      repeat (6)  step(1'b0, 1'b1);
    end

    // four writes, then two back-to-back reads
    do_reset();
    repeat (4) step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    step(1'b0, 1'b0);

    // random traffic, then drain
    repeat (300) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
    repeat (12) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    check("rd_q_drained", 64'(rd_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
